tl_cpl_tracker: RTL

//  Non-posted request tag manager and completion matcher for the TL receive path.

---
 rtl/tl_cpl_tracker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tl_cpl_tracker.sv
// Non-posted request tag allocator and completion matcher for the TL receive path.
// Tracks outstanding tags, forwards completions through a 1-entry register and retires timed-out tags.
package tl_pkg;
   typedef logic [31:0] tl_data_t;
endpackage

module tl_cpl_tracker #(
   parameter int TAG_W          = 8,
   parameter int NUM_TAGS       = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               tag_req_i,
   output logic                               tag_gnt_o,
   output logic [TAG_W-1:0]                   tag_o,
   input  logic [TAG_W-1:0]                   cpl_tag_i,
   input  tl_pkg::tl_data_t                   cpl_data_i,
   input  logic                               cpl_valid_i,
   output logic                               cpl_ready_o,
   output logic [TAG_W-1:0]                   rd_tag_o,
   output tl_pkg::tl_data_t                   rd_data_o,
   output logic                               rd_err_o,
   output logic                               rd_valid_o,
   input  logic                               rd_ready_i,
   output logic                               tmo_valid_o,
   output logic [TAG_W-1:0]                   tmo_tag_o,
   output logic [$clog2(NUM_TAGS+1)-1:0]      outstanding_o
);

   localparam int                IDX_W     = $clog2(NUM_TAGS);
   localparam int                TMR_W     = $clog2(TIMEOUT_CYCLES);
   localparam int                CNT_W     = $clog2(NUM_TAGS + 1);
   localparam logic [TAG_W:0]    TAG_LIMIT = (TAG_W + 1)'(NUM_TAGS);
   localparam logic [TMR_W-1:0]  TMR_ARM   = TMR_W'(TIMEOUT_CYCLES - 2);

   logic [NUM_TAGS-1:0]  busy_r;
   logic [NUM_TAGS-1:0]  expired_r;
   logic [TMR_W-1:0]     timer_r [NUM_TAGS];

   logic                 rd_valid_r;
   logic [TAG_W-1:0]     rd_tag_r;
   tl_pkg::tl_data_t     rd_data_r;
   logic                 rd_err_r;
   logic                 tmo_valid_r;
   logic [TAG_W-1:0]     tmo_tag_r;
   logic [CNT_W-1:0]     outstanding_r;

   logic                 free_found_s;
   logic [IDX_W-1:0]     free_idx_s;
   logic                 tmo_found_s;
   logic [IDX_W-1:0]     tmo_idx_s;
   logic                 alloc_s;
   logic                 cpl_ready_s;
   logic                 cpl_acc_s;
   logic                 cpl_in_range_s;
   logic [IDX_W-1:0]     cpl_idx_s;
   logic                 cpl_hit_s;
   logic                 tmo_fire_s;

   // Lowest free tag and lowest expired tag, scanned downward so the lowest index wins.
   always_comb begin
      free_idx_s = '0;
      tmo_idx_s  = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         free_idx_s = busy_r[i]    ? free_idx_s : IDX_W'(i);
         tmo_idx_s  = expired_r[i] ? IDX_W'(i)  : tmo_idx_s;
      end
   end

   assign free_found_s   = ~(&busy_r);
   assign tmo_found_s    = |expired_r;
   assign alloc_s        = tag_req_i & free_found_s;

   assign cpl_ready_s    = ~rd_valid_r | rd_ready_i;
   assign cpl_acc_s      = cpl_valid_i & cpl_ready_s;
   assign cpl_in_range_s = ({1'b0, cpl_tag_i} < TAG_LIMIT);
   assign cpl_idx_s      = cpl_tag_i[IDX_W-1:0];
   assign cpl_hit_s      = cpl_acc_s & cpl_in_range_s & busy_r[cpl_idx_s];
   // A completion retiring the tag chosen for timeout suppresses that timeout report.
   assign tmo_fire_s     = tmo_found_s & ~(cpl_hit_s & (cpl_idx_s == tmo_idx_s));

   assign tag_gnt_o      = alloc_s;
   assign tag_o          = TAG_W'(free_idx_s);
   assign cpl_ready_o    = cpl_ready_s;

   assign rd_valid_o     = rd_valid_r;
   assign rd_tag_o       = rd_tag_r;
   assign rd_data_o      = rd_data_r;
   assign rd_err_o       = rd_err_r;
   assign tmo_valid_o    = tmo_valid_r;
   assign tmo_tag_o      = tmo_tag_r;
   assign outstanding_o  = outstanding_r;

   // Per-tag busy, timer and expired state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r    <= '0;
         expired_r <= '0;
         for (int i = 0; i < NUM_TAGS; i++) begin
            timer_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (alloc_s && (free_idx_s == IDX_W'(i))) begin
               busy_r[i]    <= 1'b1;
               expired_r[i] <= 1'b0;
               timer_r[i]   <= '0;
            end else if ((cpl_hit_s && (cpl_idx_s == IDX_W'(i))) ||
                         (tmo_fire_s && (tmo_idx_s == IDX_W'(i)))) begin
               busy_r[i]    <= 1'b0;
               expired_r[i] <= 1'b0;
               timer_r[i]   <= '0;
            end else if (busy_r[i] && !expired_r[i]) begin
               timer_r[i]   <= timer_r[i] + TMR_W'(1);
               expired_r[i] <= (timer_r[i] == TMR_ARM);
            end else begin
               timer_r[i]   <= timer_r[i];
            end
         end
      end
   end

   // Single-entry completion output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_r <= 1'b0;
         rd_tag_r   <= '0;
         rd_data_r  <= '0;
         rd_err_r   <= 1'b0;
      end else if (cpl_acc_s) begin
         rd_valid_r <= 1'b1;
         rd_tag_r   <= cpl_tag_i;
         rd_data_r  <= cpl_data_i;
         rd_err_r   <= ~cpl_hit_s;
      end else if (rd_ready_i) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_valid_r;
      end
   end

   // Timeout report pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_valid_r <= 1'b0;
         tmo_tag_r   <= '0;
      end else begin
         tmo_valid_r <= tmo_fire_s;
         if (tmo_fire_s) begin
            tmo_tag_r <= TAG_W'(tmo_idx_s);
         end else begin
            tmo_tag_r <= tmo_tag_r;
         end
      end
   end

   // Outstanding count: at most one allocation and two retirements per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_r <= '0;
      end else begin
         outstanding_r <= outstanding_r + CNT_W'(alloc_s) - CNT_W'(cpl_hit_s) - CNT_W'(tmo_fire_s);
      end
   end

endmodule
